ram_arbiter: RTL and testbench

- Shares the single-port 512x32 synchronous RAM between two requesters: port 0 is the CPU datapath (MAR/MDR side), port 1 is the program loader / I/O side.
- Arbitrates, registers the RAM strobes, address and write data, and absorbs the RAM's one-cycle read latency.
- Returns read data with a one-cycle done pulse to the winning requester.
- Sits between the datapath/loader and the RAM; the RAM remains unchanged.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_pick.sv | 36 +++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the RAM arbiter slice.
//   ADDR_W / DATA_W : geometry of the single-port 512x32 RAM
//   state_t         : arbiter FSM states
//   OWN_CPU/OWN_IO  : requester ids (port 0 = CPU datapath, port 1 = loader/IO)
package ram_arb_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select for the RAM arbiter.
// Build option: RAM_ARB_ROUND_ROBIN_EN -- on a tie, grant the port that was
// not served last; otherwise port 0 always wins a tie.
// Ports:
//   r0_req, r1_req : live request lines
//   last_owner     : id of the most recently completed requester
//   gnt_valid      : at least one request is pending
//   gnt_id         : winning port id (OWN_CPU / OWN_IO)
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic r0_req,
    input  logic r1_req,
    input  logic last_owner,
    output logic gnt_valid,
    output logic gnt_id
);
    assign gnt_valid = r0_req | r1_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt_id = OWN_CPU;
        if (r0_req && r1_req) gnt_id = ~last_owner;
        else if (r1_req)      gnt_id = OWN_IO;
    end
`else
    // Fixed priority has no use for history.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        gnt_id = OWN_CPU;
        if (!r0_req && r1_req) gnt_id = OWN_IO;
    end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous RAM (1-cycle read latency)
// between the CPU datapath (port 0) and the loader/IO side (port 1).
// Build option: RAM_ARB_ROUND_ROBIN_EN (tie-break policy, see ram_arb_pick).
// Ports:
//   clock, clear        : clock, synchronous active-high reset
//   rX_req/we/addr/wdata: request from port X, held until rX_done
//   rX_done, rX_rdata   : one-cycle completion pulse, held read data
//   ram_read/ram_write/ram_address/ram_data_in : registered RAM controls
//   ram_data_out        : RAM read data, valid the cycle after the access edge
//   busy                : high whenever the FSM is not idle
// One access takes IDLE -> ISSUE -> CAPTURE -> DONE (4 cycles).
module ram_arbiter #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W,
    parameter int DATA_W = ram_arb_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);
    import ram_arb_pkg::*;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              r0_done_q, r0_done_d;
    logic              r1_done_q, r1_done_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
    logic              busy_q, busy_d;
    logic              gnt_valid, gnt_id;
    logic              sel_we;

    ram_arb_pick u_pick (
        .r0_req     (r0_req),
        .r1_req     (r1_req),
        .last_owner (last_owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        we_d          = we_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        r0_rdata_d    = r0_rdata_q;
        r1_rdata_d    = r1_rdata_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        r0_done_d     = 1'b0;
        r1_done_d     = 1'b0;
        sel_we        = (gnt_id == OWN_IO) ? r1_we : r0_we;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    // Latch the whole request so later input churn is ignored.
                    owner_d       = gnt_id;
                    we_d          = sel_we;
                    ram_address_d = (gnt_id == OWN_IO) ? r1_addr  : r0_addr;
                    ram_data_in_d = (gnt_id == OWN_IO) ? r1_wdata : r0_wdata;
                    ram_read_d    = ~sel_we;
                    ram_write_d   = sel_we;
                    state_d       = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                // On a write the RAM returns stale contents; drop them.
                if (!we_q) begin
                    if (owner_q == OWN_IO) r1_rdata_d = ram_data_out;
                    else                   r0_rdata_d = ram_data_out;
                end
                r0_done_d = (owner_q == OWN_CPU);
                r1_done_d = (owner_q == OWN_IO);
                state_d   = DONE;
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= IDLE;
            owner_q       <= OWN_CPU;
            last_owner_q  <= OWN_IO;
            we_q          <= 1'b0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            r0_done_q     <= 1'b0;
            r1_done_q     <= 1'b0;
            r0_rdata_q    <= '0;
            r1_rdata_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            we_q          <= we_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            r0_done_q     <= r0_done_d;
            r1_done_q     <= r1_done_d;
            r0_rdata_q    <= r0_rdata_d;
            r1_rdata_q    <= r1_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;
    assign r0_done     = r0_done_q;
    assign r1_done     = r1_done_q;
    assign r0_rdata    = r0_rdata_q;
    assign r1_rdata    = r1_rdata_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 512x32
// synchronous RAM. Honours RAM_ARB_ROUND_ROBIN_EN for the contention check.
module tb_ram_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam int NEXP = 3;
`else
    localparam int NEXP = 2;
`endif

    logic          clock = 1'b0;
    logic          clear;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_done, r1_done;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          ram_read, ram_write, busy;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem [0:511];

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    ram_arbiter dut (
        .clock(clock), .clear(clear),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_rdata(r1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    // Synchronous RAM with one-cycle read latency, plus a bench preload port.
    always @(posedge clock) begin
        if (pl_en)     mem[pl_addr] <= pl_data;
        if (ram_write) mem[ram_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    // One complete access on port p; checks strobes, latency and done pulse.
    task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        int  n;
        bit  seen;
        if (!p) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = wd; end
        else    begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = wd; end
        n = 0; seen = 0;
        while (!seen && n < 12) begin
            step();
            n++;
            if (n == 1) begin
                chk("issue_rd", {31'd0, ram_read}, {31'd0, ~we});
                chk("issue_wr", {31'd0, ram_write}, {31'd0, we});
                chk("issue_addr", {23'd0, ram_address}, {23'd0, a});
                if (we) chk("issue_wdata", ram_data_in, wd);
            end
            if (n == 2) chk("strobe_drop", {30'd0, ram_read, ram_write}, 32'd0);
            seen = p ? r1_done : r0_done;
        end
        chk("latency", n, 32'd3);
        chk("other_done", {31'd0, p ? r0_done : r1_done}, 32'd0);
        if (!p) r0_req = 0; else r1_req = 0;
        step();
        chk("done_pulse", {31'd0, p ? r1_done : r0_done}, 32'd0);
    endtask

    int           nd, t, last_t;
    bit           re0, re1;
    logic         seq [NEXP];
    int           gap [NEXP];

    initial begin
        clear = 1; r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        preload(9'd5, 32'hDEADBEEF);
        preload(9'd3, 32'hAAAA0003);
        preload(9'd7, 32'hBBBB0007);
        step();
        chk("rst_flags", {27'd0, ram_read, ram_write, r0_done, r1_done, busy}, 32'd0);
        chk("rst_addr", {23'd0, ram_address}, 32'd0);
        chk("rst_din", ram_data_in, 32'd0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);
        clear = 0;
        step();

        // Single read on port 0.
        access(0, 0, 9'd5, 32'd0);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);

        // Port 1: read, write (rdata held), read back.
        access(1, 0, 9'd5, 32'd0);
        chk("t2_rd5", r1_rdata, 32'hDEADBEEF);
        access(1, 1, 9'd9, 32'h12345678);
        chk("t2_wr_hold", r1_rdata, 32'hDEADBEEF);
        access(1, 0, 9'd9, 32'd0);
        chk("t2_rd9", r1_rdata, 32'h12345678);

        // Input churn after grant.
        r0_req = 1; r0_we = 0; r0_addr = 9'd3;
        step();
        r0_addr = 9'd7;
        chk("churn_issue_addr", {23'd0, ram_address}, 32'd3);
        step();
        chk("churn_cap_addr", {23'd0, ram_address}, 32'd3);
        step();
        chk("churn_done", {31'd0, r0_done}, 32'd1);
        chk("churn_rdata", r0_rdata, 32'hAAAA0003);
        r0_req = 0;
        step();

        // Contention: both held; a served port re-requests the cycle after done.
        r0_we = 0; r0_addr = 9'd5; r1_we = 0; r1_addr = 9'd9;
        r0_req = 1; r1_req = 1;
        nd = 0; t = 0; last_t = 0; re0 = 0; re1 = 0;
        for (int i = 0; i < NEXP; i++) begin seq[i] = 1'bx; gap[i] = 0; end
        while (nd < NEXP && t < 40) begin
            step();
            t++;
            if (re0) begin r0_req = 1; re0 = 0; end
            if (re1) begin r1_req = 1; re1 = 0; end
            if (r0_done || r1_done) begin
                seq[nd] = r1_done;
                gap[nd] = t - last_t;
                last_t  = t;
                nd++;
                if (r0_done) begin r0_req = 0; re0 = 1; end
                if (r1_done) begin r1_req = 0; re1 = 1; end
            end
        end
        r0_req = 0; r1_req = 0;
        chk("cont_count", nd, NEXP);
        chk("cont_first", {31'd0, seq[0]}, 32'd0);
        chk("cont_lat", gap[0], 32'd3);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("cont_second", {31'd0, seq[1]}, 32'd1);
        chk("cont_third", {31'd0, seq[2]}, 32'd0);
        chk("cont_gap2", gap[2], 32'd4);
`else
        chk("cont_second", {31'd0, seq[1]}, 32'd0);
`endif
        chk("cont_gap1", gap[1], 32'd4);
        step();
        chk("cont_idle", {31'd0, busy}, 32'd0);

        // Clear during CAPTURE of a read: no done, rdata cleared.
        r0_req = 1; r0_we = 0; r0_addr = 9'd5;
        step();
        step();
        chk("clr_rd_busy_pre", {31'd0, busy}, 32'd1);
        clear = 1;
        step();
        chk("clr_rd_flags", {29'd0, busy, r0_done, ram_read}, 32'd0);
        chk("clr_rd_rdata", r0_rdata, 32'd0);
        clear = 0; r0_req = 0;
        step();
        chk("clr_rd_nodone", {30'd0, r0_done, busy}, 32'd0);

        // Clear during ISSUE of a write: the write still lands.
        r1_req = 1; r1_we = 1; r1_addr = 9'd20; r1_wdata = 32'hCAFEF00D;
        step();
        chk("clr_wr_strobe", {31'd0, ram_write}, 32'd1);
        clear = 1;
        step();
        chk("clr_wr_flags", {29'd0, busy, ram_write, r1_done}, 32'd0);
        clear = 0; r1_req = 0; r1_we = 0;
        chk("clr_wr_mem", mem[20], 32'hCAFEF00D);
        step();
        access(0, 0, 9'd20, 32'd0);
        chk("clr_wr_readback", r0_rdata, 32'hCAFEF00D);

        // Boundary addresses 511 and 0, no aliasing.
        access(0, 1, 9'd511, 32'h511AAAAA);
        access(1, 1, 9'd0, 32'h00055555);
        access(0, 0, 9'd511, 32'd0);
        chk("bnd_511", r0_rdata, 32'h511AAAAA);
        access(1, 0, 9'd0, 32'd0);
        chk("bnd_0", r1_rdata, 32'h00055555);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
